nash_cipher_engine: RTL and testbench



---
 rtl/nash_cipher_engine.sv | 174 +++++++++++++++++
 tb/tb_nash_cipher_engine.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nash_cipher_engine.sv
// nash_cipher_engine: bit-serial red/blue permutation cipher.
// Loadable red/blue next-state and transform tables, a working bit ring R,
// a shadow seed ring R0 and a state pointer s. Words are processed LSB
// first, one bit per clock. The ciphertext bit of each step selects the
// red or blue branch, so encrypt and decrypt walk through the same states.
// Optional feature: define NASH_BIT_COUNT_EN to add a 32-bit bit_count output.
module nash_cipher_engine #(
    parameter int N_STATES = 256,
    parameter int STATE_W  = $clog2(N_STATES),
    parameter int DATA_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_addr,
    input  logic [STATE_W-1:0] cfg_red_next,
    input  logic               cfg_red_tf,
    input  logic [STATE_W-1:0] cfg_blue_next,
    input  logic               cfg_blue_tf,
    input  logic               cfg_ring_bit,
    input  logic [STATE_W-1:0] cfg_start_state,
    output logic               cfg_ready,
    input  logic               restart,
    input  logic               mode,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid
`ifdef NASH_BIT_COUNT_EN
    ,
    output logic [31:0]        bit_count
`endif
);

    localparam int K_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t state;

    // Permutation tables and rings
    logic [STATE_W-1:0]  red_next  [N_STATES];
    logic [STATE_W-1:0]  blue_next [N_STATES];
    logic [N_STATES-1:0] red_tf;
    logic [N_STATES-1:0] blue_tf;
    logic [N_STATES-1:0] ring;
    logic [N_STATES-1:0] ring0;

    // Working registers for the word in flight
    logic [STATE_W-1:0] s;
    logic [K_W-1:0]     k;
    logic [DATA_W-1:0]  word_q;
    logic [DATA_W-1:0]  res_q;
    logic               mode_q;

    // Per-bit datapath
    logic               bit_x;
    logic               bit_r;
    logic               bit_y;
    logic               bit_f;
    logic               bit_tf;
    logic [STATE_W-1:0] s_next;
    logic [DATA_W-1:0]  res_next;
    logic               cfg_wr;

    assign cfg_ready = (state == ST_IDLE);
    assign in_ready  = rst_n && (state == ST_IDLE) && !restart;
    assign cfg_wr    = cfg_we && cfg_ready;

    // One cipher step: result bit, ciphertext feedback, branch selection
    always_comb begin
        bit_x    = word_q[k];
        bit_r    = ring[s];
        bit_y    = bit_x ^ bit_r;
        // The feedback is always the ciphertext bit: y when encrypting, x when decrypting.
        bit_f    = mode_q ? bit_x : bit_y;
        bit_tf   = bit_f ? blue_tf[s] : red_tf[s];
        s_next   = bit_f ? blue_next[s] : red_next[s];
        res_next = res_q;
        res_next[k] = bit_y;
    end

    // Table and seed-ring writes, accepted only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the tables are real state that reset must clear, so the
            // arrays are reset element by element (this costs a reset per bit).
            for (int i = 0; i < N_STATES; i++) begin
                red_next[i]  <= '0;
                blue_next[i] <= '0;
            end
            red_tf  <= '0;
            blue_tf <= '0;
            ring0   <= '0;
        end else if (cfg_wr) begin
            red_next[cfg_addr]  <= cfg_red_next;
            blue_next[cfg_addr] <= cfg_blue_next;
            red_tf[cfg_addr]    <= cfg_red_tf;
            blue_tf[cfg_addr]   <= cfg_blue_tf;
            ring0[cfg_addr]     <= cfg_ring_bit;
        end
    end

    // Control FSM plus cipher state: accept, run DATA_W bits, present result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            s         <= '0;
            ring      <= '0;
            k         <= '0;
            word_q    <= '0;
            res_q     <= '0;
            mode_q    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef NASH_BIT_COUNT_EN
            bit_count <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates keep every read of s and ring in this
            // cycle on the old values, matching the combinational step above.
            out_valid <= 1'b0;
            if (restart) begin
                // Restart wins over everything: abort the word and reseed.
                // ring0 is read before any same-cycle table write lands.
                state <= ST_IDLE;
                s     <= cfg_start_state;
                ring  <= ring0;
`ifdef NASH_BIT_COUNT_EN
                bit_count <= '0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (in_valid) begin
                            word_q <= in_data;
                            mode_q <= mode;
                            k      <= '0;
                            state  <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        ring[s] <= bit_f ^ bit_tf;
                        s       <= s_next;
                        res_q   <= res_next;
`ifdef NASH_BIT_COUNT_EN
                        bit_count <= bit_count + 32'd1;
`endif
                        if (k == K_LAST) begin
                            out_data  <= res_next;
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nash_cipher_engine.sv
// Self-checking bench for nash_cipher_engine (N_STATES=4, DATA_W=8).
// Stimulus pushes expected words into a queue; a separate monitor pops and
// compares whenever out_valid is seen. Expected words come from a plain
// behavioural model of the red/blue cipher.
// Build with NASH_BIT_COUNT_EN defined to also cover bit_count.
module tb_nash_cipher_engine;

    localparam int N      = 4;
    localparam int SW     = 2;
    localparam int DW     = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [SW-1:0] cfg_addr = '0;
    logic [SW-1:0] cfg_red_next = '0;
    logic          cfg_red_tf = 1'b0;
    logic [SW-1:0] cfg_blue_next = '0;
    logic          cfg_blue_tf = 1'b0;
    logic          cfg_ring_bit = 1'b0;
    logic [SW-1:0] cfg_start_state = '0;
    logic          cfg_ready;
    logic          restart = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
`ifdef NASH_BIT_COUNT_EN
    logic [31:0]   bit_count;
`endif

    nash_cipher_engine #(.N_STATES(N), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_red_next    (cfg_red_next),
        .cfg_red_tf      (cfg_red_tf),
        .cfg_blue_next   (cfg_blue_next),
        .cfg_blue_tf     (cfg_blue_tf),
        .cfg_ring_bit    (cfg_ring_bit),
        .cfg_start_state (cfg_start_state),
        .cfg_ready       (cfg_ready),
        .restart         (restart),
        .mode            (mode),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid)
`ifdef NASH_BIT_COUNT_EN
        ,
        .bit_count       (bit_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q[$];

    // Behavioural model state
    int m_rn[N];
    int m_bn[N];
    bit m_rtf[N];
    bit m_btf[N];
    bit m_ring[N];
    bit m_r0[N];
    int m_s;
    int m_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_rn[i] = 0; m_bn[i] = 0; m_rtf[i] = 0; m_btf[i] = 0;
            m_ring[i] = 0; m_r0[i] = 0;
        end
        m_s = 0;
    endfunction

    function automatic void model_restart();
        m_s = m_start;
        for (int i = 0; i < N; i++) m_ring[i] = m_r0[i];
    endfunction

    // One word through the cipher: y = x ^ R[s], feedback = ciphertext bit.
    function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w, input bit dec);
        logic [DW-1:0] res = '0;
        for (int b = 0; b < DW; b++) begin
            bit x = w[b];
            bit y = x ^ m_ring[m_s];
            bit f = dec ? x : y;
            m_ring[m_s] = f ^ (f ? m_btf[m_s] : m_rtf[m_s]);
            m_s = f ? m_bn[m_s] : m_rn[m_s];
            res[b] = y;
        end
        return res;
    endfunction

    // Monitor: every out_valid pulse must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cfg_write(input int a, input int rn, input int rtf, input int bn,
                             input int btf, input int rb, input bit with_restart);
        @(negedge clk);
        cfg_addr      = SW'(a);
        cfg_red_next  = SW'(rn);
        cfg_red_tf    = rtf[0];
        cfg_blue_next = SW'(bn);
        cfg_blue_tf   = btf[0];
        cfg_ring_bit  = rb[0];
        cfg_we        = 1'b1;
        restart       = with_restart;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        restart = 1'b0;
        if (with_restart) model_restart();
        m_rn[a] = rn; m_rtf[a] = rtf[0]; m_bn[a] = bn; m_btf[a] = btf[0]; m_r0[a] = rb[0];
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        model_restart();
    endtask

    task automatic set_start(input int st);
        cfg_start_state = SW'(st);
        m_start = st;
    endtask

    task automatic setup_spec();
        for (int i = 0; i < N; i++) cfg_write(i, (i + 1) % N, 0, (i + 3) % N, 0, 0, 1'b0);
        set_start(0);
        do_restart();
    endtask

    // Handshake one word in; returns just after the accepting edge.
    task automatic accept_word(input logic [DW-1:0] w, input bit dec);
        bit ok = 1'b0;
        @(negedge clk);
        in_data  = w;
        mode     = dec;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge to out_valid; in_ready must stay low.
    task automatic wait_output();
        int lat = 0;
        bit saw_ready = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready) saw_ready = 1'b1;
        end
        check("latency", 32'(lat), 32'(DW + 1));
        check("in_ready_busy", 32'(saw_ready), 32'd0);
    endtask

    task automatic run_word(input logic [DW-1:0] w, input bit dec, input logic [DW-1:0] exp);
        accept_word(w, dec);
        exp_q.push_back(exp);
        wait_output();
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("pending_outputs", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pt[64];
        logic [DW-1:0] ct[64];
        logic [DW-1:0] e;
        bit seen;

        model_reset();
        m_start = 0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef NASH_BIT_COUNT_EN
        check("rst_bit_count", bit_count, 32'd0);
`endif

        // Directed: 0xFF encrypts to 0x0F, state returns, second word repeats
        setup_spec();
        e = model_word(8'hFF, 1'b0);
        check("model_enc_ff", 32'(e), 32'h0F);
        run_word(8'hFF, 1'b0, 8'h0F);
        e = model_word(8'hFF, 1'b0);
        run_word(8'hFF, 1'b0, 8'h0F);

        // Restart then decrypt 0x0F; restart then encrypt 0x00
        do_restart();
        e = model_word(8'h0F, 1'b1);
        run_word(8'h0F, 1'b1, 8'hFF);
        do_restart();
        e = model_word(8'h00, 1'b0);
        run_word(8'h00, 1'b0, 8'h00);

        // Random 64-word stream: encrypt, restart, decrypt back to plaintext
        do_restart();
        for (int i = 0; i < 64; i++) begin
            pt[i] = DW'($urandom);
            ct[i] = model_word(pt[i], 1'b0);
            run_word(pt[i], 1'b0, ct[i]);
        end
        do_restart();
        for (int i = 0; i < 64; i++) begin
            e = model_word(ct[i], 1'b1);
            run_word(ct[i], 1'b1, pt[i]);
        end

        // Restart at RUN bit 3 aborts the word with no output
        do_restart();
        accept_word(8'hA5, 1'b0);
        repeat (4) @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        model_restart();
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", 32'(seen), 32'd0);
        e = model_word(8'hFF, 1'b0);
        run_word(8'hFF, 1'b0, 8'h0F);

        // Config write while busy is dropped
        do_restart();
        accept_word(8'h3C, 1'b0);
        exp_q.push_back(model_word(8'h3C, 1'b0));
        @(negedge clk);
        @(negedge clk);
        check("busy_cfg_ready", 32'(cfg_ready), 32'd0);
        cfg_addr = 2'd0; cfg_red_next = 2'd2; cfg_red_tf = 1'b1;
        cfg_blue_next = 2'd2; cfg_blue_tf = 1'b1; cfg_ring_bit = 1'b1;
        cfg_we = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        drain();
        do_restart();
        e = model_word(8'hFF, 1'b0);
        run_word(8'hFF, 1'b0, e);
        e = model_word(8'h96, 1'b0);
        run_word(8'h96, 1'b0, e);

        // Simultaneous write and restart: restart uses the old seed ring
        cfg_write(1, 2, 0, 0, 0, 1, 1'b1);
        e = model_word(8'hFF, 1'b0);
        run_word(8'hFF, 1'b0, e);
        do_restart();
        e = model_word(8'hFF, 1'b0);
        run_word(8'hFF, 1'b0, e);
        cfg_write(1, 2, 0, 0, 0, 0, 1'b0);

        // Random tables, seed ring and start state: round trip
        for (int i = 0; i < N; i++)
            cfg_write(i, int'($urandom_range(N - 1)), int'($urandom_range(1)),
                      int'($urandom_range(N - 1)), int'($urandom_range(1)),
                      int'($urandom_range(1)), 1'b0);
        set_start(int'($urandom_range(N - 1)));
        do_restart();
        for (int i = 0; i < 16; i++) begin
            pt[i] = DW'($urandom);
            ct[i] = model_word(pt[i], 1'b0);
            run_word(pt[i], 1'b0, ct[i]);
        end
        do_restart();
        for (int i = 0; i < 16; i++) begin
            e = model_word(ct[i], 1'b1);
            run_word(ct[i], 1'b1, pt[i]);
        end

        // Reset mid-word: outputs drop asynchronously, tables clear
        accept_word(8'h55, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        model_reset();
        set_start(0);
        m_s = 0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef NASH_BIT_COUNT_EN
        check("midrst_bit_count", bit_count, 32'd0);
`endif
        // Cleared tables: every state maps to 0 with tf=0
        e = model_word(8'hC3, 1'b0);
        run_word(8'hC3, 1'b0, e);

        setup_spec();
        e = model_word(8'hFF, 1'b0);
        run_word(8'hFF, 1'b0, 8'h0F);
        e = model_word(8'h5A, 1'b0);
        run_word(8'h5A, 1'b0, e);
`ifdef NASH_BIT_COUNT_EN
        check("bit_count_two_words", bit_count, 32'd16);
`endif

        drain();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
